renkon_layer_sched: RTL and testbench
=====================================

RENKON_LAYER_SCHED -- requirements
Module: renkon_layer_sched

Interface
REQ-001 SHALL take parameter SCHED_DEPTH, default 8, as the descriptor table depth in layers (power of 2).
REQ-002 SHALL take parameter SCHED_LOG, default 3, equal to log2(SCHED_DEPTH).
REQ-003 SHALL have port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port desc_we  in  1  descriptor write strobe.
REQ-006 SHALL have port desc_addr  in  SCHED_LOG  descriptor write index.
REQ-007 SHALL have port desc_wdata  in  $bits(sched_desc_t)  descriptor {in_offset, out_offset, net_offset, total_out, total_in, img_size, fil_size}.
REQ-008 SHALL have port start  in  1  begin-sequence pulse.
REQ-009 SHALL have port n_layers  in  SCHED_LOG+1  layer count, sampled at start.
REQ-010 SHALL have port abort  in  1  stop-after-current-layer request.
REQ-011 SHALL have port core_ack  in  1  ack from the core controller (high = idle).
REQ-012 SHALL have port core_req  out  1  one-cycle launch pulse to the core.
REQ-013 SHALL have ports in_offset, out_offset (IMGSIZE), net_offset (RENKON_NETSIZE), and total_out, total_in, img_size, fil_size (LWIDTH), all out, as registered layer parameters to the core.
REQ-014 SHALL have ports busy  out  1 and done  out  1 (one-cycle pulse), plus layer_idx  out  SCHED_LOG giving the current layer.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_LOAD, S_REQ, S_ACKLO, S_ACKHI, S_DONE, encoded as sched_state_t.
REQ-016 S_IDLE: start with n_layers>0 SHALL go to S_LOAD with layer_idx=0; start with n_layers=0 SHALL go directly to S_DONE.
REQ-017 S_LOAD SHALL read the descriptor at layer_idx, register all parameter outputs, then go to S_REQ (1 cycle).
REQ-018 S_REQ SHALL drive core_req=1 for exactly one cycle, then go to S_ACKLO.
REQ-019 S_ACKLO SHALL wait for core_ack=0, then go to S_ACKHI.
REQ-020 S_ACKHI SHALL wait for core_ack=1; if layer_idx==n_layers-1 or abort is latched, it SHALL go to S_DONE, else it SHALL increment layer_idx and go to S_LOAD.
REQ-021 S_DONE SHALL pulse done for one cycle, clear latched abort, and return to S_IDLE.
REQ-022 Parameter outputs SHALL stay constant from S_LOAD exit until the next S_LOAD.
REQ-023 busy SHALL be 1 in every state except S_IDLE.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort SHALL be latched in any busy state; the in-flight layer SHALL always complete its ack cycle.
REQ-026 A desc_we in the same cycle as S_LOAD reading the same address SHALL return the old data (read-before-write).
REQ-027 desc_we SHALL be accepted in all states.
REQ-028 n_layers > SCHED_DEPTH SHALL be saturated to SCHED_DEPTH at sampling.
REQ-029 Latency from start to the first core_req SHALL be exactly 2 cycles.

Reset
REQ-030 rst SHALL force S_IDLE and clear core_req, busy, done, layer_idx, all parameter outputs, and latched abort to 0, asynchronously.
REQ-031 rst mid-sequence SHALL not emit done, and the descriptor contents SHALL be retained.

Configuration
REQ-032 With RENKON_SCHED_PINGPONG_EN defined, layers 1..n-1 SHALL take in_offset from the previous layer's out_offset, and the descriptor in_offset SHALL be used only for layer 0.
REQ-033 Without RENKON_SCHED_PINGPONG_EN, in_offset SHALL always come from the descriptor.

Structure
REQ-034 sched_desc_t, sched_state_t, and the SCHED_DEPTH default SHALL reside in the shared renkon package.
REQ-035 Descriptor storage SHALL be a sub-module renkon_sched_desc_ram (1 write port, 1 registered read port).

Verification
REQ-036 Write 3 descriptors, start with n_layers=3, core model acks 10 cycles after each req -> exactly 3 core_req pulses, layer_idx 0,1,2, one done.
REQ-037 start with n_layers=0 -> done 1 cycle later; core_req is never asserted.
REQ-038 abort asserted during layer 1 of 4 -> layer 1 completes, done follows, only 2 core_req pulses in total.
REQ-039 PINGPONG_EN set, layer 0 out_offset=0x100 -> layer 1 in_offset=0x100 regardless of its descriptor; with the macro off -> the descriptor value is used.
REQ-040 rst pulsed while in S_ACKLO -> all outputs 0 immediately, no done; a restart replays the same descriptors.
REQ-041 start asserted while busy -> ignored; desc_we to the address being loaded -> the old value appears on the outputs.

Source files
------------

// File: rtl/renkon_pkg.sv
// Shared renkon types and sizes: layer descriptor layout, scheduler state encoding,
// default table depth and the address/size widths used on the core interface.
package renkon_pkg;

    localparam int SCHED_DEPTH_DEF = 8;
    localparam int IMGSIZE         = 16;
    localparam int RENKON_NETSIZE  = 16;
    localparam int LWIDTH          = 12;

    // Field order matches the flat desc_wdata word, in_offset in the MSBs.
    typedef struct packed {
        logic [IMGSIZE-1:0]        in_offset;
        logic [IMGSIZE-1:0]        out_offset;
        logic [RENKON_NETSIZE-1:0] net_offset;
        logic [LWIDTH-1:0]         total_out;
        logic [LWIDTH-1:0]         total_in;
        logic [LWIDTH-1:0]         img_size;
        logic [LWIDTH-1:0]         fil_size;
    } sched_desc_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_REQ   = 3'd2,
        S_ACKLO = 3'd3,
        S_ACKHI = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/renkon_sched_desc_ram.sv
// Layer descriptor table: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module renkon_sched_desc_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // No reset on the array so the table survives a scheduler reset.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/renkon_layer_sched.sv
// Layer scheduler: walks the descriptor table and launches the core once per layer.
// Build option RENKON_SCHED_PINGPONG_EN chains in_offset from the previous layer's out_offset.
module renkon_layer_sched
    import renkon_pkg::*;
#(
    parameter int SCHED_DEPTH = SCHED_DEPTH_DEF,
    parameter int SCHED_LOG   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           desc_we,
    input  logic [SCHED_LOG-1:0]           desc_addr,
    input  logic [$bits(sched_desc_t)-1:0] desc_wdata,
    input  logic                           start,
    input  logic [SCHED_LOG:0]             n_layers,
    input  logic                           abort,
    input  logic                           core_ack,
    output logic                           core_req,
    output logic [IMGSIZE-1:0]             in_offset,
    output logic [IMGSIZE-1:0]             out_offset,
    output logic [RENKON_NETSIZE-1:0]      net_offset,
    output logic [LWIDTH-1:0]              total_out,
    output logic [LWIDTH-1:0]              total_in,
    output logic [LWIDTH-1:0]              img_size,
    output logic [LWIDTH-1:0]              fil_size,
    output logic                           busy,
    output logic                           done,
    output logic [SCHED_LOG-1:0]           layer_idx,
    output sched_state_t                   dbg_state_o
);

    localparam int              NW      = SCHED_LOG + 1;
    localparam int              DW      = $bits(sched_desc_t);
    localparam logic [NW-1:0]   DEPTH_N = NW'(SCHED_DEPTH);

    sched_state_t         state_q, state_d;
    logic [SCHED_LOG-1:0] layer_q, layer_d;
    logic [NW-1:0]        n_q, n_d;
    logic                 abort_q, abort_d;
    sched_desc_t          par_q, par_d;
    logic                 req_q, busy_q, done_q;

    logic                 rd_en;
    logic [SCHED_LOG-1:0] rd_addr;
    logic [DW-1:0]        rd_raw;
    sched_desc_t          rd_desc;
    logic [NW-1:0]        n_sat;
    logic                 last_layer;

    renkon_sched_desc_ram #(
        .DEPTH (SCHED_DEPTH),
        .AW    (SCHED_LOG),
        .DW    (DW)
    ) u_desc_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (desc_we),
        .waddr_i (desc_addr),
        .wdata_i (desc_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_raw)
    );

    assign rd_desc    = sched_desc_t'(rd_raw);
    assign n_sat      = (n_layers > DEPTH_N) ? DEPTH_N : n_layers;
    assign last_layer = ({1'b0, layer_q} == (n_q - 1'b1));

    // Core handshake: core_req is a one-cycle launch pulse; the core then drops core_ack
    // while working and raises it again when idle. A layer ends only on that rising ack.
    // The table is read on the edge entering S_LOAD, so S_LOAD only registers the word.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        n_d     = n_q;
        abort_d = abort_q;
        par_d   = par_q;
        rd_en   = 1'b0;
        rd_addr = layer_q + 1'b1;

        if (state_q != S_IDLE && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_sat;
                    layer_d = '0;
                    rd_addr = '0;
                    if (n_sat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                par_d = rd_desc;
`ifdef RENKON_SCHED_PINGPONG_EN
                if (layer_q != '0) begin
                    par_d.in_offset = par_q.out_offset;
                end
`endif
                state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_ACKLO;
            end
            S_ACKLO: begin
                if (!core_ack) begin
                    state_d = S_ACKHI;
                end
            end
            S_ACKHI: begin
                if (core_ack) begin
                    if (last_layer || abort_q) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + 1'b1;
                        rd_en   = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            n_q     <= '0;
            abort_q <= 1'b0;
            par_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            n_q     <= n_d;
            abort_q <= abort_d;
            par_q   <= par_d;
            req_q   <= (state_d == S_REQ);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign core_req    = req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign layer_idx   = layer_q;
    assign dbg_state_o = state_q;
    assign in_offset   = par_q.in_offset;
    assign out_offset  = par_q.out_offset;
    assign net_offset  = par_q.net_offset;
    assign total_out   = par_q.total_out;
    assign total_in    = par_q.total_in;
    assign img_size    = par_q.img_size;
    assign fil_size    = par_q.fil_size;

endmodule

// File: tb/tb_renkon_layer_sched.sv
// Self-checking bench for renkon_layer_sched: random descriptors and sequences against a
// table-walk reference model; honours RENKON_SCHED_PINGPONG_EN when defined.
module tb_renkon_layer_sched;
    import renkon_pkg::*;

    localparam int DEPTH = 8;
    localparam int LOG   = 3;
    localparam int DW    = $bits(sched_desc_t);
    localparam int W     = LOG + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  desc_we    = 1'b0;
    logic [LOG-1:0]        desc_addr  = '0;
    logic [DW-1:0]         desc_wdata = '0;
    logic                  start      = 1'b0;
    logic [LOG:0]          n_layers   = '0;
    logic                  abort      = 1'b0;
    logic                  core_ack   = 1'b1;
    logic                  core_req;
    logic [IMGSIZE-1:0]    in_offset, out_offset;
    logic [RENKON_NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0]     total_out, total_in, img_size, fil_size;
    logic                  busy, done;
    logic [LOG-1:0]        layer_idx;
    sched_state_t          dbg_state;
    logic [W-1:0]          obs_vec;

    renkon_layer_sched #(.SCHED_DEPTH(DEPTH), .SCHED_LOG(LOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .desc_we     (desc_we),
        .desc_addr   (desc_addr),
        .desc_wdata  (desc_wdata),
        .start       (start),
        .n_layers    (n_layers),
        .abort       (abort),
        .core_ack    (core_ack),
        .core_req    (core_req),
        .in_offset   (in_offset),
        .out_offset  (out_offset),
        .net_offset  (net_offset),
        .total_out   (total_out),
        .total_in    (total_in),
        .img_size    (img_size),
        .fil_size    (fil_size),
        .busy        (busy),
        .done        (done),
        .layer_idx   (layer_idx),
        .dbg_state_o (dbg_state)
    );

    assign obs_vec = {layer_idx, in_offset, out_offset, net_offset,
                      total_out, total_in, img_size, fil_size};

    // ---------------- scoreboard state ----------------
    sched_desc_t  desc_m [DEPTH];
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int first_req_cyc = -1;
    int done_cyc = -1;
    int lo_dly = 0;
    int hi_dly = 10;
    bit core_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Core model: ack drops lo_dly cycles after a request, rises hi_dly cycles later.
    always @(negedge clk) begin
        if (core_req) begin
            core_busy = 1'b1;
            repeat (lo_dly) @(negedge clk);
            core_ack = 1'b0;
            repeat (hi_dly) @(negedge clk);
            core_ack = 1'b1;
            core_busy = 1'b0;
        end
    end

    // Monitor: every launch must match the next expected layer.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (core_req) begin
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("req_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("req_params", obs_vec, e);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_desc(input int addr, input sched_desc_t d);
        @(posedge clk); #1;
        desc_we = 1'b1;
        desc_addr = LOG'(addr);
        desc_wdata = d;
        @(posedge clk); #1;
        desc_we = 1'b0;
        desc_m[addr] = d;
    endtask

    function automatic sched_desc_t rand_desc();
        logic [DW-1:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return sched_desc_t'(r);
    endfunction

    task automatic run_seq(input int n, input int abort_at, input bit poke_start, input bit we_in_load);
        int n_eff, n_exec, req_base, done_base, start_cyc, guard;
        bit aborted, poked, wrote;
        sched_desc_t d, new_d;
        n_eff  = (n > DEPTH) ? DEPTH : n;
        n_exec = (abort_at >= 0 && abort_at < n_eff) ? abort_at + 1 : n_eff;
        for (int i = 0; i < n_exec; i++) begin
            d = desc_m[i];
`ifdef RENKON_SCHED_PINGPONG_EN
            if (i > 0) d.in_offset = desc_m[i-1].out_offset;
`endif
            exp_q.push_back({LOG'(i), d});
        end
        new_d = rand_desc();
        req_base = req_cnt;
        done_base = done_cnt;
        first_req_cyc = -1;
        aborted = 1'b0;
        poked = 1'b0;
        wrote = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        n_layers = (LOG+1)'(n);
        start_cyc = cyc;
        guard = 0;
        while (done_cnt == done_base && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
            start = 1'b0;
            abort = 1'b0;
            desc_we = 1'b0;
            n_layers = (LOG+1)'(n);
            if (guard == 1) check_eq("busy_after_start", busy, 1);
            if (abort_at >= 0 && !aborted && (req_cnt - req_base) == abort_at + 1) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (poke_start && !poked && (req_cnt - req_base) == 1) begin
                start = 1'b1;
                n_layers = (LOG+1)'(1);
                poked = 1'b1;
            end
            if (we_in_load && !wrote && dbg_state == S_LOAD && layer_idx == LOG'(1)) begin
                desc_addr = LOG'(1);
                desc_wdata = new_d;
                desc_we = 1'b1;
                wrote = 1'b1;
            end
        end
        if (guard >= 2000) check_eq("done_timeout", 0, 1);
        if (we_in_load) check_eq("we_in_load_hit", wrote, 1);
        start = 1'b0;
        abort = 1'b0;
        desc_we = 1'b0;
        if (wrote) desc_m[1] = new_d;
        check_eq("req_count", req_cnt - req_base, n_exec);
        if (n_eff > 0) check_eq("start_to_req", first_req_cyc - start_cyc, 2);
        else           check_eq("start_to_done", done_cyc - start_cyc, 1);
        check_eq("exp_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        check_eq("done_once", done_cnt - done_base, 1);
        check_eq("idle_after", {busy, 3'(dbg_state)}, {1'b0, 3'(S_IDLE)});
    endtask

    task automatic reset_mid_run();
        int guard, done_base;
        lo_dly = 30;
        hi_dly = 3;
        done_base = done_cnt;
        exp_q.push_back({LOG'(0), desc_m[0]});
        @(posedge clk); #1;
        start = 1'b1;
        n_layers = (LOG+1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (dbg_state != S_ACKLO && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("reached_acklo", 3'(dbg_state), 3'(S_ACKLO));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_outputs", {core_req, busy, done, 3'(dbg_state), obs_vec}, 0);
        guard = 0;
        while (core_busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("core_settled", core_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        check_eq("no_done_after_rst", done_cnt - done_base, 0);
        exp_q.delete();
        lo_dly = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sched_desc_t d;
        int n, ab;
        #1;
        check_eq("reset_outputs", {core_req, busy, done, 3'(dbg_state), obs_vec}, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_reset_idle", {core_req, busy, done, 3'(dbg_state), obs_vec}, 0);

        for (int i = 0; i < DEPTH; i++) write_desc(i, rand_desc());

        lo_dly = 0; hi_dly = 10;
        run_seq(3, -1, 1'b0, 1'b0);           // three layers, ack 10 cycles after req
        run_seq(0, -1, 1'b0, 1'b0);           // empty sequence
        hi_dly = 4;
        run_seq(4, 1, 1'b0, 1'b0);            // abort during layer 1 of 4

        d = desc_m[0]; d.out_offset = 16'h0100; write_desc(0, d);
        d = desc_m[1]; d.in_offset  = 16'hBEEF; write_desc(1, d);
        run_seq(2, -1, 1'b0, 1'b0);           // in_offset chaining vs descriptor

        run_seq(4, -1, 1'b1, 1'b1);           // start while busy, write during load
        run_seq(12, -1, 1'b0, 1'b0);          // count above depth saturates

        reset_mid_run();
        run_seq(3, -1, 1'b0, 1'b0);           // replay after reset

        for (int k = 0; k < 10; k++) begin
            write_desc($urandom_range(0, DEPTH-1), rand_desc());
            lo_dly = $urandom_range(0, 3);
            hi_dly = $urandom_range(1, 6);
            n  = $urandom_range(0, 15);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1;
            run_seq(n, ab, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
